// File: rtl/logic_sched_pkg.sv
// Shared opcode and FSM definitions for the round-robin logic-unit scheduler.
package logic_sched_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Shared WIDTH-bit gate datapath: opcode-selected bitwise AND/OR/XOR/NAND/NOR/NOT/PASS.
module logic_slice
  import logic_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler time-sharing one logic_slice among N_REQ requesters.
module logic_unit_scheduler
  import logic_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] a_in,
  input  logic [WIDTH*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       result,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic                   err
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] slice_y;
  logic             slice_ill;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic_slice #(.WIDTH(WIDTH)) u_slice (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .y       (slice_y),
    .illegal (slice_ill)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    gnt_d    = '0;
    valid_d  = 1'b0;
    result_d = result_q;
    res_id_d = res_id_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = EXEC;
          op_d    = op[3*int'(win_idx) +: 3];
          a_d     = a_in[WIDTH*int'(win_idx) +: WIDTH];
          b_d     = b_in[WIDTH*int'(win_idx) +: WIDTH];
          id_d    = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          ptr_d   = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      EXEC: begin
        result_d = slice_y;
        res_id_d = id_q;
        err_d    = slice_ill;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments with a synchronous reset that overrides every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      result_q <= '0;
      res_id_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      res_id_q <= res_id_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == EXEC);
  assign result    = result_q;
  assign res_valid = valid_q;
  assign res_id    = res_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_logic_unit_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] op;
  logic [W*N-1:0] a_in;
  logic [W*N-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   result;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic           err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .result    (result),
    .res_valid (res_valid),
    .res_id    (res_id),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: one pending operation, a priority pointer, expected outputs.
  int           m_ptr;
  bit           m_exec;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b;
  int           m_id;

  logic [N-1:0]   exp_gnt;
  logic           exp_busy, exp_valid, exp_err;
  logic [W-1:0]   exp_result;
  logic [IDW-1:0] exp_id;

  function automatic logic [W:0] ref_eval(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (o)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic model_edge();
    exp_gnt   = '0;
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    if (rst) begin
      m_ptr      = 0;
      m_exec     = 1'b0;
      exp_result = '0;
      exp_id     = '0;
      exp_err    = 1'b0;
    end else if (m_exec) begin
      {exp_err, exp_result} = ref_eval(m_op, m_a, m_b);
      exp_id    = IDW'(m_id);
      exp_valid = 1'b1;
      m_exec    = 1'b0;
    end else if (req != '0) begin
      int w = -1;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (w < 0 && req[j]) w = j;
      end
      m_op     = op[3*w +: 3];
      m_a      = a_in[W*w +: W];
      m_b      = b_in[W*w +: W];
      m_id     = w;
      m_ptr    = (w + 1) % N;
      m_exec   = 1'b1;
      exp_gnt  = N'(1) << w;
      exp_busy = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("gnt", gnt, exp_gnt);
    check("busy", busy, exp_busy);
    check("res_valid", res_valid, exp_valid);
    check("result", result, exp_result);
    check("res_id", res_id, exp_id);
    check("err", err, exp_err);
  endtask

  logic         r_req [N];
  logic [2:0]   r_op  [N];
  logic [W-1:0] r_a   [N];
  logic [W-1:0] r_b   [N];

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req[i]         = r_req[i];
      op[3*i +: 3]   = r_op[i];
      a_in[W*i +: W] = r_a[i];
      b_in[W*i +: W] = r_b[i];
    end
  endtask

  task automatic new_op(input int i);
    r_op[i] = 3'($urandom_range(0, 7));
    r_a[i]  = W'($urandom);
    r_b[i]  = W'($urandom);
  endtask

  logic [W-1:0] all_res [4] = '{8'h05, 8'hAF, 8'hAA, 8'hFA};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
    step(); step();
    check("rst_gnt", gnt, 0);
    check("rst_result", result, 0);
    check("rst_valid", res_valid, 0);
    rst = 1'b0;
    step();

    // Single request on index 1: AND F0 & 3C.
    req = 4'b0010; op[5:3] = 3'd0; a_in[15:8] = 8'hF0; b_in[15:8] = 8'h3C;
    step(); check("single_gnt", gnt, 4'b0010);
    req = '0;
    step();
    check("single_valid", res_valid, 1);
    check("single_result", result, 8'h30);
    check("single_id", res_id, 1);
    check("single_err", err, 0);

    // All requesters high from reset, requester i presenting opcode i.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; op = {3'd3, 3'd2, 3'd1, 3'd0};
    a_in = {4{8'hA5}}; b_in = {4{8'h0F}};
    for (int g = 0; g < 4; g++) begin
      step(); check("all_gnt", gnt, 1 << g);
      step(); check("all_result", result, all_res[g]); check("all_id", res_id, g);
    end
    step(); check("all_gnt_wrap", gnt, 4'b0001);
    req = '0;
    step();

    // Wrap and fairness.
    req = 4'b1000;
    step(); check("wrap_gnt3", gnt, 4'b1000);
    req = 4'b1001;
    step();
    step(); check("wrap_gnt0", gnt, 4'b0001);
    req = 4'b1000;
    step();
    step(); check("wrap_gnt3b", gnt, 4'b1000);
    req = '0;
    step();

    // Illegal opcode on requester 2.
    req = 4'b0100; op[8:6] = 3'd7; a_in[23:16] = 8'hFF; b_in[23:16] = 8'h55;
    step();
    req = '0;
    step();
    check("ill_valid", res_valid, 1);
    check("ill_err", err, 1);
    check("ill_result", result, 8'h00);
    check("ill_id", res_id, 2);

    // NOT and PASS ignore B.
    req = 4'b0001; op[2:0] = 3'd5; a_in[7:0] = 8'h5A; b_in[7:0] = W'($urandom);
    step(); req = '0;
    step(); check("not_result", result, 8'hA5);
    req = 4'b0001; op[2:0] = 3'd6; b_in[7:0] = W'($urandom);
    step(); req = '0;
    step(); check("pass_result", result, 8'h5A);

    // Reset during EXEC discards the operation and resets ptr.
    req = 4'b0100; op[8:6] = 3'd0;
    step(); check("rexec_busy", busy, 1);
    rst = 1'b1; req = 4'b0110;
    step();
    check("rexec_valid", res_valid, 0);
    check("rexec_result", result, 0);
    check("rexec_busy0", busy, 0);
    rst = 1'b0;
    step(); check("rexec_first_gnt", gnt, 4'b0010);
    req = '0;
    step();

    // Random traffic obeying the hold-until-grant protocol.
    for (int i = 0; i < N; i++) begin
      r_req[i] = 1'b0;
      new_op(i);
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) begin
          r_req[i] = 1'($urandom_range(0, 1));
          new_op(i);
        end else if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
          new_op(i);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      pack();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
